// File: rtl/axis_testpattern_checker.sv
// AXI-Stream counter test-pattern checker: locks onto a wrapping counter sequence and
// reports mismatches. Define AXIS_TESTPATTERN_CHECKER_THROTTLE_EN to throttle s_axis_tready.
module axis_testpattern_checker #(
  parameter int unsigned S00_AXIS_TDATA_WIDTH = 24,
  parameter int unsigned COUNTER_START        = 1,
  parameter int unsigned COUNTER_END          = 10,
  parameter int unsigned COUNTER_INCR         = 1,
  parameter int unsigned READY_DIVIDER        = 2
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_aresetn,
  input  logic                            enable,
  input  logic                            clear,
  input  logic [S00_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic                            locked,
  output logic                            error,
  output logic [15:0]                     error_count,
  output logic [31:0]                     beat_count,
  output logic [S00_AXIS_TDATA_WIDTH-1:0] expected
);

  localparam int unsigned W = S00_AXIS_TDATA_WIDTH;
  localparam logic [W-1:0] StartVal = W'(COUNTER_START);
  localparam logic [W:0]   EndVal   = (W+1)'(COUNTER_END);
  localparam logic [W:0]   IncrVal  = (W+1)'(COUNTER_INCR);

  typedef enum logic [1:0] {StIdle, StSync, StLocked} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   expected_q, expected_d;
  logic           error_q, error_d;
  logic [15:0]    err_cnt_q, err_cnt_d;
  logic [31:0]    beat_cnt_q, beat_cnt_d;
  logic           active;
  logic           ready;
  logic           accept;

  // Sum is one bit wider than the data so the wrap compare never sees an overflow.
  function automatic logic [W-1:0] succ(input logic [W-1:0] v);
    logic [W:0] sum;
    sum = {1'b0, v} + IncrVal;
    return (sum > EndVal) ? StartVal : sum[W-1:0];
  endfunction

  assign active = (state_q != StIdle);

`ifdef AXIS_TESTPATTERN_CHECKER_THROTTLE_EN
  localparam int unsigned DivW = (READY_DIVIDER > 1) ? $clog2(READY_DIVIDER) : 1;

  logic [DivW-1:0] div_q, div_d;

  // Held at zero while idle so ready is high on the first active cycle.
  always_comb begin
    div_d = div_q;
    if (!active) begin
      div_d = '0;
    end else if (div_q == DivW'(READY_DIVIDER - 1)) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign ready = active && (div_q == '0);
`else
  // The divider setting only matters for the throttled build.
  if (READY_DIVIDER == 0) begin : g_div_unused
  end

  assign ready = active;
`endif

  assign accept = s_axis_tvalid && ready;

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    error_d    = 1'b0;
    err_cnt_d  = err_cnt_q;
    beat_cnt_d = beat_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StSync;
        end
      end
      StSync: begin
        if (accept && (s_axis_tdata == StartVal)) begin
          state_d    = StLocked;
          expected_d = succ(StartVal);
        end
      end
      StLocked: begin
        if (accept) begin
          if (s_axis_tdata == expected_q) begin
            expected_d = succ(expected_q);
          end else begin
            state_d = StSync;
            error_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
              err_cnt_d = err_cnt_q + 16'd1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
    end

    if (clear) begin
      err_cnt_d  = '0;
      beat_cnt_d = '0;
    end

    if (!enable) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q    <= StIdle;
      expected_q <= StartVal;
      error_q    <= 1'b0;
      err_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      error_q    <= error_d;
      err_cnt_q  <= err_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign s_axis_tready = ready;
  assign locked        = (state_q == StLocked);
  assign error         = error_q;
  assign error_count   = err_cnt_q;
  assign beat_count    = beat_cnt_q;
  assign expected      = expected_q;

endmodule

// File: doc/axis_testpattern_checker.md
AXIS_TESTPATTERN_CHECKER -- requirements
Module: axis_testpattern_checker

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- S00_AXIS_TDATA_WIDTH, 24, stream data width.
- COUNTER_START, 1, first sequence value.
- COUNTER_END, 10, last value before wrap.
- COUNTER_INCR, 1, step.
- READY_DIVIDER, 2, tready throttle period (used only with the throttle macro).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- s_axis_aclk, in, 1, sole clock.
- s_axis_aresetn, in, 1, reset; asynchronous, active-low.
- enable, in, 1, checker run.
- clear, in, 1, synchronous counter clear.
- s_axis_tdata, in, S00_AXIS_TDATA_WIDTH, stream data.
- s_axis_tvalid, in, 1, stream valid.
- s_axis_tready, out, 1, stream ready.
- locked, out, 1, sequence lock held.
- error, out, 1, one-cycle mismatch pulse.
- error_count, out, 16, saturating mismatch count.
- beat_count, out, 32, wrapping accepted-beat count.
- expected, out, S00_AXIS_TDATA_WIDTH, next expected value.

Function
REQ-003 A beat SHALL be accepted only on a rising edge with s_axis_tvalid and s_axis_tready both high.
REQ-004 The FSM SHALL have three states:
- IDLE: SHALL move to SYNC when enable=1.
- SYNC: SHALL move to LOCKED on an accepted beat equal to COUNTER_START.
- LOCKED: SHALL move to SYNC on a mismatched beat.
REQ-005 enable=0 SHALL force IDLE on the next edge from any state, with s_axis_tready=0 in IDLE.
REQ-006 In SYNC, accepted beats not equal to COUNTER_START SHALL be discarded, with no error and no error_count change.
REQ-007 On lock or a matching beat, expected SHALL update to succ(value): value+COUNTER_INCR, or COUNTER_START if value+COUNTER_INCR > COUNTER_END. The sum SHALL be computed at S00_AXIS_TDATA_WIDTH+1 bits so it cannot overflow.
REQ-008 In LOCKED, an accepted beat != expected SHALL, on the following edge:
- assert error for exactly one cycle;
- increment error_count, saturating at 0xFFFF;
- deassert locked;
- enter SYNC.
REQ-009 locked SHALL be 1 exactly when the state is LOCKED; a lock beat SHALL set locked the cycle after acceptance.
REQ-010 beat_count SHALL increment on every accepted beat in SYNC or LOCKED, wrapping at 2^32.
REQ-011 clear=1 SHALL zero error_count and beat_count on the next edge without affecting FSM state or expected. Clear SHALL win over a simultaneous increment.
REQ-012 error, locked and the counters SHALL be registered, with one-cycle latency from the accepting edge.
REQ-013 Without throttling, s_axis_tready SHALL be high in SYNC and LOCKED.

Reset
REQ-014 Asserting s_axis_aresetn low SHALL immediately set:
- state IDLE;
- s_axis_tready=0, locked=0, error=0;
- error_count=0, beat_count=0;
- expected=COUNTER_START.
REQ-015 Reset mid-stream SHALL discard lock; after release the checker SHALL re-sync from SYNC.

Configuration
REQ-016 With AXIS_TESTPATTERN_CHECKER_THROTTLE_EN defined, s_axis_tready SHALL be high for one cycle in every READY_DIVIDER cycles while in SYNC or LOCKED. The divider counter SHALL be reset to 0 and SHALL assert on count 0. Without the macro, REQ-013 SHALL apply and no divider logic SHALL exist.

Verification
REQ-017 Reset released, enable=1, stream 1..10 repeating, tvalid=1 -> locked=1 the cycle after the first beat 1; error never pulses; beat_count counts every accepted beat.
REQ-018 Stream 1,2,3,5,6 -> one error pulse after beat 5; error_count=1; locked=0; relock at the next beat 1.
REQ-019 Wrap check: beat 10 followed by 1 -> no error; beat 10 followed by 11 -> error.
REQ-020 Stream starting at 7 -> beats 7..10 discarded with error=0, beat_count=4, lock on the following 1.
REQ-021 enable low for 25 cycles mid-stream -> tready=0, counters hold; after re-enable the checker re-syncs, no error.
REQ-022 With THROTTLE_EN and READY_DIVIDER=2 -> tready toggles 1,0,1,0 from the SYNC entry; sequence accepted without error.
